// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} ps2_state_t;

    // True when data byte plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
        return ^{code, par};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Key event FIFO with valid/ready read port and a sticky drop flag.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  ps2_event_t push_data,
    output ps2_event_t rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    ps2_event_t     mem_q [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_q, rd_ptr_q;
    logic           overflow_q;
    logic           empty, full, pop, wr_en, drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && rd_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop)  overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow = overflow_q;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0 prefixes into key events, buffers them.
// Define PS2_PARITY_CHECK_EN to drop frames with even parity.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK50MHZ,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] ev_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;
    logic fall;

    ps2_state_t    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_d, frame_err_q;
    logic          byte_done, par_ok;
    logic          byte_valid_q;
    logic [7:0]    byte_q;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic          push;
    ps2_event_t    ev, head;

`ifdef PS2_PARITY_CHECK_EN
    logic par_q, par_d;
    assign par_ok = odd_parity_ok(shift_q, par_q);
`else
    assign par_ok = 1'b1;
`endif

    // Idle-high reset values keep a spurious falling edge from appearing after rst.
    always_ff @(posedge CLK50MHZ) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    assign fall = clk_prev_q && !clk_sync_q;

    always_ff @(posedge CLK50MHZ) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tmo_q        <= '0;
            frame_err_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tmo_q        <= tmo_d;
            frame_err_q  <= err_d;
            byte_valid_q <= byte_done;
            byte_q       <= shift_q;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q        <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d     = par_q;
`endif
        if (state_q == StIdle || fall) tmo_d = '0;
        else                           tmo_d = tmo_q + 1'b1;

        if (state_q != StIdle && !fall && tmo_q == TMO_LAST) begin
            state_d = StIdle;
            err_d   = 1'b1;
            tmo_d   = '0;
        end else if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_sync_q) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d   = data_sync_q;
`endif
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (data_sync_q && par_ok) byte_done = 1'b1;
                    else                       err_d     = 1'b1;
                end
            endcase
        end
    end

    // Prefix bytes only arm the pending flags; the next plain byte carries them out.
    always_comb begin
        push    = 1'b0;
        ext_d   = ext_q;
        brk_d   = brk_q;
        ev.ext  = ext_q;
        ev.brk  = brk_q;
        ev.code = byte_q;
        if (byte_valid_q) begin
            if (byte_q == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == PS2_PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    ps2_event_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK50MHZ),
        .rst      (rst),
        .push     (push),
        .push_data(ev),
        .rd_data  (head),
        .rd_valid (ev_valid),
        .rd_ready (ev_ready),
        .overflow (overflow)
    );

    assign ev_data   = head;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Randomised bench for ps2_key_event_rx against a byte-stream event model.
module tb_ps2_key_event_rx;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 50000;
    localparam int          H     = 4;

    logic       CLK50MHZ = 1'b0;
    logic       rst      = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ev_ready = 1'b0;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic       overflow;
    logic       frame_err;

    ps2_key_event_rx #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK50MHZ (CLK50MHZ),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ev_data  (ev_data),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected events in arrival order, plus pending prefix flags.
    logic [9:0] exp_q[$];
    bit m_ext = 0, m_brk = 0;
    bit cap_model = 0, exp_ovf = 0;

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (cap_model && exp_q.size() >= DEPTH) exp_ovf = 1;
            else exp_q.push_back({m_ext, m_brk, b});
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    int cyc = 0;
    int stop_fall_cyc = 0;
    int rise_cyc = -1;
    int err_cnt = 0;
    bit rand_ready = 0;
    bit valid_prev = 0, hold_prev = 0;
    logic [9:0] data_prev = '0;

    always @(posedge CLK50MHZ) cyc++;

    initial begin
        forever begin
            @(posedge CLK50MHZ);
            #1;
            ev_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    always @(negedge CLK50MHZ) begin
        if (rst) begin
            valid_prev = 0;
            hold_prev  = 0;
        end else begin
            if (frame_err) err_cnt++;
            if (ev_valid && !valid_prev) rise_cyc = cyc;
            if (hold_prev && ev_valid) check("hold_stable", ev_data, data_prev);
            if (ev_valid && ev_ready) begin
                if (exp_q.size() == 0) check("spurious_event", ev_valid, 1'b0);
                else check("event", ev_data, exp_q.pop_front());
            end
            hold_prev  = ev_valid && !ev_ready;
            data_prev  = ev_data;
            valid_prev = ev_valid;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK50MHZ);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            cycles(H);
            ps2_clk = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            cycles(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cycles(2 * H);
    endtask

    task automatic send_good(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 0, 0, 11);
    endtask

    task automatic drain();
        int n = 0;
        rand_ready = 1;
        while (exp_q.size() != 0 && n < 3000) begin
            cycles(1);
            n++;
        end
        check("drain", exp_q.size(), 0);
        cycles(10);
    endtask

    task automatic directed(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int n, input logic [9:0] want, input string tag);
        logic [7:0] bs [3];
        bs[0] = b0;
        bs[1] = b1;
        bs[2] = b2;
        rand_ready = 0;
        cycles(4);
        for (int i = 0; i < n; i++) send_good(bs[i]);
        check(tag, ev_data, want);
        check({tag, "_valid"}, ev_valid, 1'b1);
        drain();
    endtask

    initial begin
        int e0;
        logic [7:0] b;
        int r;

        rst = 1;
        cycles(5);
        check("rst_valid", ev_valid, 1'b0);
        check("rst_data", ev_data, 10'h000);
        check("rst_ovf", overflow, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        rst = 0;
        cycles(3);
        check("idle_valid", ev_valid, 1'b0);

        rise_cyc = -1;
        directed(8'h1C, 8'h00, 8'h00, 1, 10'h01C, "make_1c");
        check("latency", rise_cyc - stop_fall_cyc, 4);
        directed(8'hF0, 8'h1C, 8'h00, 2, 10'h11C, "brk_1c");
        directed(8'hE0, 8'hF0, 8'h75, 3, 10'h375, "ext_brk_75");

        rand_ready = 1;
        repeat (40) begin
            r = $urandom_range(0, 9);
            b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
            send_good(b);
        end
        send_good(8'h11);
        drain();

        e0 = err_cnt;
        send_frame(8'h5A, 0, 1, 11);
        cycles(10);
        check("stop_err", err_cnt - e0, 1);
        drain();

        e0 = err_cnt;
        rand_ready = 0;
        cycles(4);
`ifdef PS2_PARITY_CHECK_EN
        send_frame(8'h1C, 1, 0, 11);
        cycles(10);
        check("parity_err", err_cnt - e0, 1);
        check("parity_noevent", ev_valid, 1'b0);
`else
        model_byte(8'h1C);
        send_frame(8'h1C, 1, 0, 11);
        check("parity_ignored", ev_data, 10'h01C);
        check("parity_noerr", err_cnt - e0, 0);
`endif
        drain();

        e0 = err_cnt;
        send_frame(8'hA5, 0, 0, 5);
        cycles(TMO + 20);
        check("timeout_err", err_cnt - e0, 1);
        directed(8'h29, 8'h00, 8'h00, 1, 10'h029, "after_timeout");

        rand_ready = 0;
        cycles(4);
        cap_model = 1;
        exp_ovf = 0;
        for (int i = 0; i < 9; i++) send_good(8'h10 + 8'(i));
        cycles(10);
        check("overflow", overflow, exp_ovf);
        check("ovf_valid", ev_valid, 1'b1);
        check("ovf_head", ev_data, 10'h010);
        cap_model = 0;
        drain();
        check("drained_valid", ev_valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        send_frame(8'h3C, 0, 0, 6);
        rst = 1;
        m_ext = 0;
        m_brk = 0;
        cycles(3);
        check("rst_clr_ovf", overflow, 1'b0);
        rst = 0;
        cycles(3);
        directed(8'h4B, 8'h00, 8'h00, 1, 10'h04B, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_rx.md
PS2_KEY_EVENT_RX -- requirements
Module: ps2_key_event_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of buffered key events; power of two, 2..64.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, CLK50MHZ cycles without a PS/2 falling edge before a partial frame is discarded (1 ms).
REQ-003 SHALL have port CLK50MHZ, input, 1, system clock.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port ps2_clk, input, 1, raw asynchronous PS/2 clock line.
REQ-006 SHALL have port ps2_data, input, 1, raw asynchronous PS/2 data line.
REQ-007 SHALL have port ev_data, output, 10, head event {ext, brk, code[7:0]}.
REQ-008 SHALL have port ev_valid, output, 1, FIFO non-empty.
REQ-009 SHALL have port ev_ready, input, 1, consumer accepts the head event.
REQ-010 SHALL have port overflow, output, 1, sticky: an event was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit, bad parity, or timeout.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers, then detect falling edges of the synchronised clock.
REQ-013 SHALL run a frame FSM IDLE->DATA->PARITY->STOP->IDLE, advancing only on detected falling edges.
REQ-014 IDLE SHALL leave on a falling edge with data=0; data=1 SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-015 DATA SHALL shift in 8 bits, LSB first, then move to PARITY.
REQ-016 PARITY SHALL capture the bit and move to STOP.
REQ-017 STOP SHALL accept the byte when data=1 (and parity is odd where checked); otherwise it SHALL pulse frame_err and drop the byte.
REQ-018 Any state other than IDLE with TIMEOUT_CYCLES cycles and no falling edge SHALL return to IDLE and pulse frame_err.
REQ-019 Byte decode SHALL work as follows:
- 0xE0 sets pending ext.
- 0xF0 sets pending brk.
- Any other byte produces event {ext, brk, byte} and clears both pending flags.
- Prefixes alone SHALL produce no event.
REQ-020 Event latency SHALL be ev_valid high 2 cycles after the STOP-edge cycle when the FIFO was empty.
REQ-021 Handshake: the head SHALL be popped on a cycle with ev_valid&&ev_ready; ev_data SHALL remain stable while ev_valid&&!ev_ready.
REQ-022 On a full FIFO, a new event SHALL be dropped, overflow SHALL set, and contents SHALL be unchanged.
REQ-023 Push and pop in the same cycle while full SHALL succeed for both; push and pop while empty SHALL push only.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH, using an extra MSB for the full/empty distinction.
REQ-025 overflow SHALL clear only on rst.

Reset
REQ-026 On rst, the FSM SHALL go to IDLE, and the bit counter, timeout counter, pending ext/brk, and FIFO pointers SHALL be cleared.
REQ-027 Output reset values SHALL be ev_valid=0, ev_data=0, overflow=0, frame_err=0.
REQ-028 rst asserted mid-frame SHALL discard the partial frame, and no event SHALL result from the remaining bits.

Configuration
REQ-029 With PS2_PARITY_CHECK_EN defined, even parity over 9 bits SHALL drop the byte and pulse frame_err.
REQ-030 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be ignored, and only the stop bit and timeout SHALL raise frame_err.

Structure
REQ-031 Package ps2_pkg SHALL hold:
- the event typedef (ext, brk, code)
- constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0
- the frame FSM state enum
REQ-032 The FIFO SHALL be the sub-module ps2_event_fifo (parameter FIFO_DEPTH, 10-bit entries, valid/ready read port).

Verification
REQ-033 Frame 0x1C with odd parity -> ev_data=10'h01C, ev_valid=1.
REQ-034 Frames F0,1C -> a single event 10'h11C.
REQ-035 Frames E0,F0,75 -> a single event 10'h375.
REQ-036 With ev_ready=0, 9 make codes at FIFO_DEPTH=8 -> overflow=1; draining yields the first 8 codes in order.
REQ-037 Frame 0x1C with a wrong parity bit -> with the macro: frame_err pulse, no event; without the macro: event 10'h01C.
REQ-038 Clock stalls after 4 data bits for 50000 cycles -> frame_err pulse, FSM in IDLE; the next full frame 0x29 -> 10'h029.
